// File: rtl/viterbi_pkg.sv
// Trellis helpers shared by the ACS array: expected code symbols, the initial
// path metric and predecessor indexing for a rate-1/2 shift-register code.
package viterbi_pkg;

  function automatic int parity(int v);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++) p = p ^ ((v >> i) & 1);
    return p;
  endfunction

  // Branch-metric slice index {c0,c1} for register contents r = {u, p}.
  function automatic int exp_sym(int k, int g0, int g1, int r);
    int mask;
    mask = (1 << k) - 1;
    return 2 * parity(r & g0 & mask) + parity(r & g1 & mask);
  endfunction

  function automatic int init_metric(int pm_w);
    return 1 << (pm_w - 2);
  endfunction

  // Predecessor j of next state s is {s[sw-2:0], j}.
  function automatic int pred_idx(int s, int sw, int j);
    return ((s << 1) | j) & ((1 << sw) - 1);
  endfunction

  function automatic int new_bit(int s, int sw);
    return (s >> (sw - 1)) & 1;
  endfunction

endpackage

// File: rtl/acs_unit.sv
// One add-compare-select cell: both candidates at PM_W+1 bits, ties go to the
// even predecessor.
module acs_unit #(
  parameter int PM_W = 8,
  parameter int BM_W = 2
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W:0]   metric,
  output logic            dec
);

  logic [PM_W:0] cand0;
  logic [PM_W:0] cand1;

  assign cand0  = {1'b0, pm0} + {{(PM_W + 1 - BM_W){1'b0}}, bm0};
  assign cand1  = {1'b0, pm1} + {{(PM_W + 1 - BM_W){1'b0}}, bm1};
  assign dec    = (cand1 < cand0);
  assign metric = dec ? cand1 : cand0;

endmodule

// File: rtl/acs_array.sv
// Add-compare-select array over 2^(K-1) trellis states with frame restart,
// path-metric renormalisation, best-state search and a one-deep output register.
module acs_array import viterbi_pkg::*; #(
  parameter int K     = 3,
  parameter int G0    = 'o7,
  parameter int G1    = 'o5,
  parameter int BM_W  = 2,
  parameter int PM_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bm_valid,
  output logic                      bm_ready,
  input  logic                      bm_first,
  input  logic [4*BM_W-1:0]         bm,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [(1 << (K-1))-1:0]   dec_bits,
  output logic [K-2:0]              best_state,
  output logic [PM_W-1:0]           best_metric,
  output logic                      norm_event,
  output logic [CNT_W-1:0]          step_cnt
);

  localparam int NSTATE = 1 << (K - 1);
  localparam int SW     = K - 1;
  localparam int INIT   = init_metric(PM_W);

  function automatic logic [PM_W-1:0] init_vec(int idx);
    return (idx == 0) ? '0 : PM_W'(INIT);
  endfunction

  function automatic logic [PM_W-1:0] norm_metric(logic [PM_W-1:0] m, logic clr);
    logic [PM_W-1:0] r;
    r = m;
    if (clr) r[PM_W-1] = 1'b0;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [PM_W-1:0]   pm_p1     [NSTATE];
  logic [PM_W-1:0]   pm_old_p0 [NSTATE];
  logic [PM_W:0]     new_p0    [NSTATE];
  logic [PM_W-1:0]   nm_p0     [NSTATE];
  logic              dec_w_p0  [NSTATE];
  logic [NSTATE-1:0] dec_p0;
  logic              norm_p0;
  logic [SW-1:0]     best_idx_p0;
  logic [PM_W-1:0]   best_val_p0;
  logic              accept;

  logic              vld_p1;
  logic [NSTATE-1:0] dec_p1;
  logic [SW-1:0]     best_idx_p1;
  logic [PM_W-1:0]   best_val_p1;
  logic              norm_p1;
  logic [CNT_W-1:0]  cnt_p1;

  assign bm_ready = !vld_p1 || dec_ready;
  assign accept   = bm_valid && bm_ready;

  // Stage p0: old-metric selection and the combinational ACS cells.
  always_comb begin
    for (int i = 0; i < NSTATE; i++)
      pm_old_p0[i] = bm_first ? init_vec(i) : pm_p1[i];
  end

  for (genvar s = 0; s < NSTATE; s++) begin : g_acs
    localparam int U    = new_bit(s, SW);
    localparam int P0   = pred_idx(s, SW, 0);
    localparam int P1   = pred_idx(s, SW, 1);
    localparam int SYM0 = exp_sym(K, G0, G1, (U << SW) | P0);
    localparam int SYM1 = exp_sym(K, G0, G1, (U << SW) | P1);

    acs_unit #(
      .PM_W (PM_W),
      .BM_W (BM_W)
    ) u_acs (
      .pm0    (pm_old_p0[P0]),
      .pm1    (pm_old_p0[P1]),
      .bm0    (bm[SYM0*BM_W +: BM_W]),
      .bm1    (bm[SYM1*BM_W +: BM_W]),
      .metric (new_p0[s]),
      .dec    (dec_w_p0[s])
    );
  end

  // Renormalise when every metric sits in the upper half; bit PM_W never sets
  // under the width constraint but is folded in so the test stays safe.
  always_comb begin
    norm_p0 = 1'b1;
    dec_p0  = '0;
    for (int i = 0; i < NSTATE; i++) begin
      norm_p0   = norm_p0 & (new_p0[i][PM_W] | new_p0[i][PM_W-1]);
      dec_p0[i] = dec_w_p0[i];
    end
    for (int i = 0; i < NSTATE; i++)
      nm_p0[i] = norm_metric(new_p0[i][PM_W-1:0], norm_p0);
  end

  always_comb begin
    best_idx_p0 = '0;
    best_val_p0 = nm_p0[0];
    for (int i = 1; i < NSTATE; i++) begin
      if (nm_p0[i] < best_val_p0) begin
        best_val_p0 = nm_p0[i];
        best_idx_p0 = SW'(i);
      end
    end
  end

  // Stage p1: path metrics and the held decision word.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      dec_p1      <= '0;
      best_idx_p1 <= '0;
      best_val_p1 <= '0;
      norm_p1     <= 1'b0;
      cnt_p1      <= '0;
      for (int i = 0; i < NSTATE; i++) pm_p1[i] <= init_vec(i);
    end else if (accept) begin
      vld_p1      <= 1'b1;
      dec_p1      <= dec_p0;
      best_idx_p1 <= best_idx_p0;
      best_val_p1 <= best_val_p0;
      norm_p1     <= norm_p0;
      cnt_p1      <= bm_first ? CNT_W'(1) : sat_inc(cnt_p1);
      for (int i = 0; i < NSTATE; i++) pm_p1[i] <= nm_p0[i];
    end else if (dec_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign dec_valid   = vld_p1;
  assign dec_bits    = dec_p1;
  assign best_state  = best_idx_p1;
  assign best_metric = best_val_p1;
  assign norm_event  = norm_p1;
  assign step_cnt    = cnt_p1;

endmodule
